// File: rtl/pcie_mwr_tlp_gen_if.sv
// Request and TLP-stream bundles for the memory-request TLP generator.
// The generator is slave on the request side and master on the TLP side.
interface mwr_req_if #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 256,
    parameter int CHUNK_MAX_BEATS = 4
);
    logic [ADDR_WIDTH-1:0]                 addr;
    logic [7:0]                            length;
    logic [15:0]                           bdf;
    logic                                  is_memwrite;
    logic [DATA_WIDTH*CHUNK_MAX_BEATS-1:0] wdata;
    logic                                  valid;
    logic                                  ready;

    modport master (output addr, length, bdf, is_memwrite, wdata, valid, input ready);
    modport slave  (input addr, length, bdf, is_memwrite, wdata, valid, output ready);
endinterface

interface tlp_stream_if #(
    parameter int DATA_WIDTH = 256
);
    logic [DATA_WIDTH-1:0] data;
    logic [7:0]            keep;
    logic                  sop;
    logic                  eop;
    logic                  valid;
    logic                  ready;

    modport master (output data, keep, sop, eop, valid, input ready);
    modport slave  (input data, keep, sop, eop, valid, output ready);
endinterface

// File: rtl/pcie_mwr_tlp_gen.sv
// Serialises one decoded MWr/MRd request into a 3DW-header TLP on a 256-bit
// stream (header beat, then payload beats), assigning tags and dropping bad lengths.
module pcie_mwr_tlp_gen #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 256,
    parameter int CHUNK_MAX_BEATS = 4
) (
    input  logic         clk,
    input  logic         rst,
    mwr_req_if.slave     req,
    tlp_stream_if.master tlp,
    output logic         err_drop
);
    localparam int BEAT_W = (CHUNK_MAX_BEATS > 1) ? $clog2(CHUNK_MAX_BEATS) : 1;

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t                                state_q, state_d;
    logic [29:0]                           addr_q;
    logic [7:0]                            length_q;
    logic [15:0]                           bdf_q;
    logic                                  memwrite_q;
    logic [DATA_WIDTH*CHUNK_MAX_BEATS-1:0] wdata_q;
    logic [7:0]                            tag_q;
    logic [BEAT_W-1:0]                     beat_q;

    logic        accept;
    logic        req_legal;
    logic        len_in_range;
    logic [4:0]  last_beat;
    logic        data_eop;
    logic [31:0] dw0, dw1, dw2;

    assign accept       = req.valid && req.ready;
    assign len_in_range = (req.length != 8'd0) && (req.length <= 8'd32);
    // Writes must carry whole 256-bit beats; reads may ask for any DW count.
    assign req_legal    = req.is_memwrite ? (len_in_range && (req.length[2:0] == 3'd0))
                                          : len_in_range;

    assign last_beat = length_q[7:3] - 5'd1;
    assign data_eop  = (5'(beat_q) == last_beat);

    assign dw0 = {(memwrite_q ? 3'b010 : 3'b000), 5'b0, 14'b0, 2'b0, length_q};
    assign dw1 = {bdf_q, tag_q, ((length_q == 8'd1) ? 4'h0 : 4'hF), 4'hF};
    assign dw2 = {addr_q, 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        req.ready = (state_q == IDLE);
        tlp.valid = 1'b0;
        tlp.sop   = 1'b0;
        tlp.eop   = 1'b0;
        tlp.keep  = 8'h00;
        tlp.data  = '0;
        case (state_q)
            IDLE: begin
                if (accept && req_legal) state_d = HDR;
            end
            HDR: begin
                tlp.valid      = 1'b1;
                tlp.sop        = 1'b1;
                tlp.eop        = !memwrite_q;
                tlp.keep       = 8'h07;
                tlp.data[95:0] = {dw2, dw1, dw0};
                if (tlp.ready) state_d = memwrite_q ? DATA : IDLE;
            end
            DATA: begin
                tlp.valid = 1'b1;
                tlp.eop   = data_eop;
                tlp.keep  = 8'hFF;
                tlp.data  = wdata_q[beat_q*DATA_WIDTH +: DATA_WIDTH];
                if (tlp.ready && data_eop) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments; the payload store is reset too, so a reset never exposes stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            length_q   <= '0;
            bdf_q      <= '0;
            memwrite_q <= 1'b0;
            wdata_q    <= '0;
            tag_q      <= '0;
            beat_q     <= '0;
            err_drop   <= 1'b0;
        end else begin
            err_drop <= accept && !req_legal;
            if (accept) begin
                addr_q     <= req.addr[31:2];
                length_q   <= req.length;
                bdf_q      <= req.bdf;
                memwrite_q <= req.is_memwrite;
                wdata_q    <= req.wdata;
            end
            // The tag is consumed when the header leaves, so dropped requests never burn one.
            if (state_q == HDR && tlp.ready) begin
                tag_q  <= tag_q + 8'd1;
                beat_q <= '0;
            end
            if (state_q == DATA && tlp.ready) beat_q <= beat_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_pcie_mwr_tlp_gen.sv
// Directed bench for pcie_mwr_tlp_gen: vector table of requests with
// hand-computed headers, plus backpressure, reset and tag-wrap sequences.
module tb_pcie_mwr_tlp_gen;
    localparam int AW = 32;
    localparam int DW = 256;
    localparam int NB = 4;

    logic clk = 1'b0;
    logic rst;
    logic err_drop;
    always #5 clk = ~clk;

    mwr_req_if    #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CHUNK_MAX_BEATS(NB)) req ();
    tlp_stream_if #(.DATA_WIDTH(DW)) tlp ();

    pcie_mwr_tlp_gen #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CHUNK_MAX_BEATS(NB)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .tlp      (tlp),
        .err_drop (err_drop)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [15:0] bdf;
        logic        mw;
        logic        exp_err;
        int          exp_beats;
        logic [31:0] dw0;
        logic [31:0] dw1;
        logic [31:0] dw2;
    } vec_t;

    vec_t vecs [10];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Payload beat k of request tag v: each DW distinct so reordering is visible.
    function automatic logic [255:0] pat(input int v, input int k);
        logic [255:0] r;
        for (int j = 0; j < 8; j++) r[32*j +: 32] = {8'(8'hA0 + k), 8'(v), 8'(j), 8'h5A};
        return r;
    endfunction

    task automatic drive_req(input vec_t e, input int v);
        @(negedge clk);
        req.addr        = e.addr;
        req.length      = e.len;
        req.bdf         = e.bdf;
        req.is_memwrite = e.mw;
        for (int k = 0; k < NB; k++) req.wdata[k*DW +: DW] = pat(v, k);
        req.valid = 1'b1;
        check("in_ready_idle", 256'(req.ready), 256'd1);
        @(posedge clk);
        #1 req.valid = 1'b0;
    endtask

    // Collects one TLP with tlp_ready held high and checks every beat.
    task automatic collect(input vec_t e, input int v);
        int  nb   = 0;
        bit  done = 1'b0;
        tlp.ready = 1'b1;
        @(negedge clk);
        check("err_drop", 256'(err_drop), 256'(e.exp_err));
        if (e.exp_err) begin
            check("no_tlp_valid", 256'(tlp.valid), 256'd0);
            @(negedge clk);
            check("err_drop_pulse", 256'(err_drop), 256'd0);
            check("no_tlp_valid2", 256'(tlp.valid), 256'd0);
            check("in_ready_after_drop", 256'(req.ready), 256'd1);
            return;
        end
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (tlp.valid) begin
                if (nb == 0) begin
                    check("hdr_sop", 256'(tlp.sop), 256'd1);
                    check("hdr_keep", 256'(tlp.keep), 256'h07);
                    check("hdr_upper_zero", 256'(tlp.data[255:96]), 256'd0);
                    check("hdr_dw0", 256'(tlp.data[31:0]), 256'(e.dw0));
                    check("hdr_dw1", 256'(tlp.data[63:32]), 256'(e.dw1));
                    check("hdr_dw2", 256'(tlp.data[95:64]), 256'(e.dw2));
                end else begin
                    check("data_sop", 256'(tlp.sop), 256'd0);
                    check("data_keep", 256'(tlp.keep), 256'hFF);
                    check("data_payload", tlp.data, pat(v, nb - 1));
                end
                check("eop", 256'(tlp.eop), 256'(nb == e.exp_beats - 1));
                if (tlp.eop) done = 1'b1;
                nb++;
            end
        end
        check("eop_seen", 256'(done), 256'd1);
        check("beat_count", 256'(nb), 256'(e.exp_beats));
        @(negedge clk);
        check("idle_valid", 256'(tlp.valid), 256'd0);
        check("idle_in_ready", 256'(req.ready), 256'd1);
    endtask

    initial begin
        vec_t e;
        logic [255:0] held;

        vecs[0] = '{32'h1000_0040, 8'd32, 16'h0200, 1'b1, 1'b0, 5, 32'h4000_0020, 32'h0200_00FF, 32'h1000_0040};
        vecs[1] = '{32'h0000_0020, 8'd1,  16'h0100, 1'b0, 1'b0, 1, 32'h0000_0001, 32'h0100_010F, 32'h0000_0020};
        vecs[2] = '{32'h0000_0080, 8'd12, 16'h0300, 1'b1, 1'b1, 0, 32'h0, 32'h0, 32'h0};
        vecs[3] = '{32'h0000_1000, 8'd8,  16'h0300, 1'b1, 1'b0, 2, 32'h4000_0008, 32'h0300_02FF, 32'h0000_1000};
        vecs[4] = '{32'hFFFF_FFFC, 8'd32, 16'hABCD, 1'b0, 1'b0, 1, 32'h0000_0020, 32'hABCD_03FF, 32'hFFFF_FFFC};
        vecs[5] = '{32'h0000_0100, 8'd0,  16'h0001, 1'b0, 1'b1, 0, 32'h0, 32'h0, 32'h0};
        vecs[6] = '{32'h8000_0100, 8'd24, 16'h0001, 1'b1, 1'b0, 4, 32'h4000_0018, 32'h0001_04FF, 32'h8000_0100};
        vecs[7] = '{32'h0000_0200, 8'd33, 16'h0002, 1'b0, 1'b1, 0, 32'h0, 32'h0, 32'h0};
        vecs[8] = '{32'h1234_5670, 8'd16, 16'hFFFF, 1'b1, 1'b0, 3, 32'h4000_0010, 32'hFFFF_05FF, 32'h1234_5670};
        vecs[9] = '{32'h0000_0043, 8'd2,  16'h0010, 1'b0, 1'b0, 1, 32'h0000_0002, 32'h0010_06FF, 32'h0000_0040};

        rst = 1'b1;
        req.valid = 1'b0;
        req.addr = '0; req.length = '0; req.bdf = '0; req.is_memwrite = 1'b0; req.wdata = '0;
        tlp.ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 256'(tlp.valid), 256'd0);
        check("rst_sop_eop_keep", 256'({tlp.sop, tlp.eop, tlp.keep}), 256'd0);
        check("rst_data", tlp.data, 256'd0);
        check("rst_err_drop", 256'(err_drop), 256'd0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 256'(req.ready), 256'd1);

        for (int i = 0; i < 10; i++) begin
            drive_req(vecs[i], i);
            collect(vecs[i], i);
        end

        // Backpressure: 3 stalled cycles in HDR, 2 in DATA, tag 7 expected.
        e = '{32'h0000_0040, 8'd8, 16'h0042, 1'b1, 1'b0, 2, 32'h4000_0008, 32'h0042_07FF, 32'h0000_0040};
        tlp.ready = 1'b0;
        drive_req(e, 30);
        @(negedge clk);
        held = tlp.data;
        check("bp_hdr_dw1", 256'(held[63:32]), 256'(e.dw1));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_hdr_stable", tlp.data, held);
            check("bp_hdr_valid", 256'({tlp.valid, tlp.sop, tlp.eop}), 256'b110);
            check("bp_hdr_in_ready", 256'(req.ready), 256'd0);
        end
        tlp.ready = 1'b1;
        @(negedge clk);
        tlp.ready = 1'b0;
        check("bp_data_payload", tlp.data, pat(30, 0));
        check("bp_data_eop", 256'({tlp.valid, tlp.sop, tlp.eop}), 256'b101);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("bp_data_stable", tlp.data, pat(30, 0));
            check("bp_data_valid", 256'(tlp.valid), 256'd1);
            check("bp_data_in_ready", 256'(req.ready), 256'd0);
        end
        tlp.ready = 1'b1;
        @(negedge clk);
        check("bp_done_valid", 256'(tlp.valid), 256'd0);
        check("bp_done_in_ready", 256'(req.ready), 256'd1);

        // Reset mid-DATA of a 4-beat write.
        e = '{32'h0000_2000, 8'd32, 16'h0005, 1'b1, 1'b0, 5, 32'h4000_0020, 32'h0005_08FF, 32'h0000_2000};
        drive_req(e, 40);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_in_data", 256'({tlp.valid, tlp.sop}), 256'b10);
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 256'(tlp.valid), 256'd0);
        check("rst_mid_ctrl", 256'({tlp.sop, tlp.eop, tlp.keep}), 256'd0);
        check("rst_mid_data", tlp.data, 256'd0);
        @(negedge clk);
        rst = 1'b0;
        e = '{32'h0000_0100, 8'd4, 16'h0007, 1'b0, 1'b0, 1, 32'h0000_0004, 32'h0007_00FF, 32'h0000_0100};
        drive_req(e, 41);
        collect(e, 41);

        // Tag wrap: fresh reset, then 257 single-payload-beat writes.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 257; i++) begin
            e = '{32'h0000_3000, 8'd8, 16'h0009, 1'b1, 1'b0, 2, 32'h4000_0008,
                  {16'h0009, 8'(i % 256), 8'hFF}, 32'h0000_3000};
            drive_req(e, i);
            collect(e, i);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
